// File: rtl/seq_left_shifter_pkg.sv
// Shared types and sizes for the sequential left shifter.
// Build option: LSHIFT_ROTATE_EN adds a per-request rotate mode.
package seq_left_shifter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int CNT_W   = $clog2(SHAMT_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/seq_left_shifter_if.sv
// Request/result handshake bundle for the left shifter.
// Build option: LSHIFT_ROTATE_EN adds in_rotate.
interface seq_left_shifter_if
  import seq_left_shifter_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
`ifdef LSHIFT_ROTATE_EN
  logic               in_rotate;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

`ifdef LSHIFT_ROTATE_EN
  modport master (
    output in_valid, in_data, in_shamt,
    output in_rotate, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_shamt,
    input  in_rotate, out_ready,
    output in_ready, out_valid, out_data
  );
`else
  modport master (
    output in_valid, in_data, in_shamt,
    output out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_shamt,
    input  out_ready,
    output in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/seq_left_shifter_lshift_stage.sv
// One power-of-two left shift/rotate stage.
// Pure combinational; enable=0 passes data through.
module lshift_stage #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic             rotate,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] rol;

  assign shl = data_in << DIST;
  assign rol = shl | (data_in >> (WIDTH - DIST));

  assign data_out = !enable ? data_in :
                    rotate  ? rol     : shl;

endmodule

// File: rtl/seq_left_shifter.sv
// Multi-cycle logical left shifter, one 2^k stage per clock.
// Build option: LSHIFT_ROTATE_EN enables per-request rotate.
module seq_left_shifter
  import seq_left_shifter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_left_shifter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SHAMT_W - 1);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   nxt;
  logic [SHAMT_W-1:0] shamt_q;
  logic [CNT_W-1:0]   cnt;
  logic               vld;
  logic               rot_q;
  logic               accept;
  logic [WIDTH-1:0]   stg [SHAMT_W];

  assign bus.in_ready  = (state == IDLE) ||
                         (state == DONE && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld;
  assign bus.out_data  = work;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stg
    lshift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stg (
      .data_in  (work),
      .enable   (shamt_q[k]),
      .rotate   (rot_q),
      .data_out (stg[k])
    );
  end

  // Select the stage output that belongs to the current cycle
  always_comb begin
    nxt = work;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (cnt == CNT_W'(k)) nxt = stg[k];
    end
  end

`ifdef LSHIFT_ROTATE_EN
  // Rotate mode is captured with the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rot_q <= 1'b0;
    else if (accept) rot_q <= bus.in_rotate;
  end
`else
  assign rot_q = 1'b0;
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      shamt_q <= '0;
      cnt     <= '0;
      vld     <= 1'b0;
    end else if (accept) begin
      state   <= SHIFT;
      work    <= bus.in_data;
      shamt_q <= bus.in_shamt;
      cnt     <= '0;
      vld     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        SHIFT: begin
          work <= nxt;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
            vld   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
